video_pattern_gen: RTL and testbench

- Parametrised video timing and test-pattern generator for the VGA/MDA bench.
- Derives a pixel enable from the board clock and generates h/v counters, sync pulses with configurable polarity, and a blanking-aware active flag.
- Drives an N-bit-per-channel RGB pattern chosen from eight run-time modes.
- Sits directly under the top level and feeds the resistor-DAC pins; replaces the fixed single-pattern timing-plus-box logic.

---
 rtl/video_pkg.sv | 45 ++++
 rtl/video_timing.sv | 82 ++++++++
 rtl/video_pattern_gen.sv | 186 ++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg
// Shared definitions for the video timing / test-pattern generator:
//   - 640x480@60 timing defaults (25 MHz pixel rate from a 50 MHz clock)
//   - line/frame total helpers
//   - the run-time pattern-mode encoding
// No ports; imported by video_timing and video_pattern_gen.
package video_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_CW        = 3;
    localparam int DEF_BORDER    = 2;
    localparam int DEF_GRID_LOG2 = 4;

    // Pixels per line including blanking.
    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including blanking.
    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef enum logic [2:0] {
        PAT_BORDER = 3'd0,
        PAT_VLINES = 3'd1,
        PAT_FILL   = 3'd2,
        PAT_CHECK  = 3'd3,
        PAT_BARS   = 3'd4,
        PAT_GRAD   = 3'd5,
        PAT_SCROLL = 3'd6,
        PAT_BLACK  = 3'd7
    } pat_mode_e;

endpackage

// File: rtl/video_timing.sv
// video_timing
// Pixel-rate divider, horizontal/vertical counters and the combinational
// sync/active flags for the current counter position.
// Ports:
//   clk, rst_n  - system clock, synchronous active-low reset
//   pix_en      - high for the clk in which the divider is on its last count;
//                 the counters step on this clk edge (combinational strobe)
//   h, v        - current pixel / line counters (11 bits, registered)
//   active      - h,v inside the visible area
//   hsync/vsync - sync levels for h,v with the configured polarity
module video_timing
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = DEF_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_en,
    output logic [10:0] h,
    output logic [10:0] v,
    output logic        active,
    output logic        hsync,
    output logic        vsync
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [10:0] H_LAST =
        11'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [10:0] V_LAST =
        11'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);

    // Window limits are 12 bits wide: a sync window may end exactly at 2048.
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [11:0]      h_ext;
    logic [11:0]      v_ext;

    assign pix_en = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (pix_en) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    assign h_ext  = {1'b0, h};
    assign v_ext  = {1'b0, v};
    assign active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign hsync  = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? HS_POL : ~HS_POL;
    assign vsync  = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? VS_POL : ~VS_POL;

endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Video timing plus run-time selectable test pattern for the resistor DAC.
// Ports:
//   clk, rst_n   - system clock, synchronous active-low reset
//   mode[2:0]    - pattern select, taken only at the first pixel of a frame
//   pix_en       - one-clk strobe per pixel
//   x, y         - pixel position of the currently presented outputs
//   active       - presented pixel is in the visible area
//   hsync, vsync - sync outputs (polarity set by HS_POL / VS_POL)
//   r, g, b      - CW-bit colour channels, forced to 0 during blanking
//   frame_start  - pulses with pix_en when the presented pixel is (0,0)
//   frame_cnt    - frames since reset, wraps 255 -> 0
//
// Output handshake: pix_en is the valid strobe. Every other output changes
// only in the clk where pix_en is high and holds otherwise; there is no
// ready, the display cannot stall the generator.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   CW        = DEF_CW,
    parameter int   BORDER    = DEF_BORDER,
    parameter int   GRID_LOG2 = DEF_GRID_LOG2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    mode,
    output logic          pix_en,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam logic [11:0] X_LO = 12'(BORDER);
    localparam logic [11:0] X_HI = 12'(H_ACTIVE - BORDER);
    localparam logic [11:0] Y_LO = 12'(BORDER);
    localparam logic [11:0] Y_HI = 12'(V_ACTIVE - BORDER);

    logic          stb;
    logic [10:0]   h;
    logic [10:0]   v;
    logic          t_active;
    logic          t_hsync;
    logic          t_vsync;

    logic [2:0]    mode_q;
    logic          frame_now;
    logic [2:0]    mode_eff;
    logic [7:0]    fc_eff;

    logic          pat_on;
    logic [2:0]    bar_k;
    logic [10:0]   scroll_sum;
    logic [CW-1:0] pr;
    logic [CW-1:0] pg;
    logic [CW-1:0] pb;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (stb),
        .h      (h),
        .v      (v),
        .active (t_active),
        .hsync  (t_hsync),
        .vsync  (t_vsync)
    );

    // The (0,0) pixel already uses the mode and frame number being latched
    // on this edge, so a whole frame is drawn with one mode and one count.
    assign frame_now = stb && (h == 11'd0) && (v == 11'd0);
    assign mode_eff  = frame_now ? mode : mode_q;
    assign fc_eff    = frame_now ? frame_cnt + 8'd1 : frame_cnt;

    always_comb begin
        pat_on     = 1'b0;
        pr         = '0;
        pg         = '0;
        pb         = '0;
        scroll_sum = h + v + {3'b000, fc_eff};
        // Bar index (x*8)/H_ACTIVE as a count of the seven thresholds
        // x*8 >= i*H_ACTIVE that have been crossed.
        bar_k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if ({h, 3'b000} >= 14'(i * H_ACTIVE)) begin
                bar_k = bar_k + 3'd1;
            end
        end
        case (pat_mode_e'(mode_eff))
            PAT_BORDER: pat_on = ({1'b0, h} < X_LO) || ({1'b0, h} >= X_HI) ||
                                 ({1'b0, v} < Y_LO) || ({1'b0, v} >= Y_HI);
            PAT_VLINES: pat_on = (h[GRID_LOG2-1:0] == '0);
            PAT_FILL:   pat_on = 1'b1;
            PAT_CHECK:  pat_on = h[GRID_LOG2] ^ v[GRID_LOG2];
            PAT_BARS: begin
                pr = {CW{bar_k[2]}};
                pg = {CW{bar_k[1]}};
                pb = {CW{bar_k[0]}};
            end
            PAT_GRAD: begin
                pr = h[GRID_LOG2+CW-1:GRID_LOG2];
                pg = h[GRID_LOG2+CW-1:GRID_LOG2];
                pb = h[GRID_LOG2+CW-1:GRID_LOG2];
            end
            PAT_SCROLL: pat_on = scroll_sum[GRID_LOG2];
            PAT_BLACK:  pat_on = 1'b0;
            default:    pat_on = 1'b0;
        endcase
        if (pat_on) begin
            pr = '1;
            pg = '1;
            pb = '1;
        end
        if (!t_active) begin
            pr = '0;
            pg = '0;
            pb = '0;
        end
    end

    // Output stage: captures the pixel the counters point at on the strobe
    // edge, so every output describes the same pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_en      <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            mode_q      <= 3'd0;
            frame_cnt   <= 8'd0;
        end else begin
            pix_en      <= stb;
            frame_start <= frame_now;
            if (stb) begin
                x      <= h;
                y      <= v;
                active <= t_active;
                hsync  <= t_hsync;
                vsync  <= t_vsync;
                r      <= pr;
                g      <= pg;
                b      <= pb;
            end
            if (frame_now) begin
                mode_q    <= mode;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen
// Two generator instances on one clock and reset:
//   main  - CLK_DIV=2, mixed sync polarity, reduced frame size
//   small - CLK_DIV=1, HS_POL=1, 8x4 visible area, runs through frame_cnt wrap
// A reference model predicts every pixel from its index in the pixel stream;
// a monitor compares the DUT whenever it presents a pixel (pix_en) and checks
// that outputs hold between pixels.
module tb_video_pattern_gen;

    localparam int CW = 3;

    localparam int   M_HA = 100, M_HFP = 4, M_HS = 8, M_HBP = 8;
    localparam int   M_VA = 20,  M_VFP = 1, M_VS = 2, M_VBP = 3;
    localparam logic M_HPOL = 1'b0, M_VPOL = 1'b1;
    localparam int   M_DIV = 2, M_BORDER = 2, M_G = 4;

    localparam int   S_HA = 8, S_HFP = 1, S_HS = 2, S_HBP = 1;
    localparam int   S_VA = 4, S_VFP = 1, S_VS = 1, S_VBP = 1;
    localparam logic S_HPOL = 1'b1, S_VPOL = 1'b0;
    localparam int   S_DIV = 1, S_BORDER = 1, S_G = 1;

    localparam int M_FRAME_CLKS = (M_HA + M_HFP + M_HS + M_HBP) *
                                  (M_VA + M_VFP + M_VS + M_VBP) * M_DIV;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int hpol; int vpol; int div; int border; int g;
    } cfg_t;

    typedef struct packed {
        logic        is_rst;
        logic        pix_en;
        logic        fs;
        logic [10:0] x;
        logic [10:0] y;
        logic        act;
        logic        hs;
        logic        vs;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [2:0]  b;
        logic [7:0]  fc;
    } pix_t;

    // ---------------------------------------------------------------- clock/reset
    logic       clk;
    logic       rst_n;
    logic [2:0] mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUTs
    logic        m_pix_en, m_fs, m_act, m_hs, m_vs;
    logic [10:0] m_x, m_y;
    logic [2:0]  m_r, m_g, m_b;
    logic [7:0]  m_fc;
    logic        s_pix_en, s_fs, s_act, s_hs, s_vs;
    logic [10:0] s_x, s_y;
    logic [2:0]  s_r, s_g, s_b;
    logic [7:0]  s_fc;

    video_pattern_gen #(
        .H_ACTIVE(M_HA), .H_FP(M_HFP), .H_SYNC(M_HS), .H_BP(M_HBP),
        .V_ACTIVE(M_VA), .V_FP(M_VFP), .V_SYNC(M_VS), .V_BP(M_VBP),
        .HS_POL(M_HPOL), .VS_POL(M_VPOL), .CLK_DIV(M_DIV), .CW(CW),
        .BORDER(M_BORDER), .GRID_LOG2(M_G)
    ) u_dut_main (
        .clk(clk), .rst_n(rst_n), .mode(mode), .pix_en(m_pix_en),
        .x(m_x), .y(m_y), .active(m_act), .hsync(m_hs), .vsync(m_vs),
        .r(m_r), .g(m_g), .b(m_b), .frame_start(m_fs), .frame_cnt(m_fc)
    );

    video_pattern_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HS_POL(S_HPOL), .VS_POL(S_VPOL), .CLK_DIV(S_DIV), .CW(CW),
        .BORDER(S_BORDER), .GRID_LOG2(S_G)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n), .mode(mode), .pix_en(s_pix_en),
        .x(s_x), .y(s_y), .active(s_act), .hsync(s_hs), .vsync(s_vs),
        .r(s_r), .g(s_g), .b(s_b), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    // ---------------------------------------------------------------- reference model
    function automatic cfg_t get_cfg(input int d);
        cfg_t c;
        if (d == 0) begin
            c.ha = M_HA; c.hfp = M_HFP; c.hs = M_HS; c.hbp = M_HBP;
            c.va = M_VA; c.vfp = M_VFP; c.vs = M_VS; c.vbp = M_VBP;
            c.hpol = int'(M_HPOL); c.vpol = int'(M_VPOL);
            c.div = M_DIV; c.border = M_BORDER; c.g = M_G;
        end else begin
            c.ha = S_HA; c.hfp = S_HFP; c.hs = S_HS; c.hbp = S_HBP;
            c.va = S_VA; c.vfp = S_VFP; c.vs = S_VS; c.vbp = S_VBP;
            c.hpol = int'(S_HPOL); c.vpol = int'(S_VPOL);
            c.div = S_DIV; c.border = S_BORDER; c.g = S_G;
        end
        return c;
    endfunction

    function automatic int line_px(input int d);
        cfg_t c;
        c = get_cfg(d);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int frame_px(input int d);
        cfg_t c;
        c = get_cfg(d);
        return line_px(d) * (c.va + c.vfp + c.vs + c.vbp);
    endfunction

    function automatic pix_t reset_rec(input int d);
        cfg_t c;
        pix_t e;
        c = get_cfg(d);
        e = '0;
        e.is_rst = 1'b1;
        e.hs = (c.hpol == 0);
        e.vs = (c.vpol == 0);
        return e;
    endfunction

    // Expected outputs for pixel number n since reset, drawn with mode fm.
    function automatic pix_t model_pixel(input int d, input int n, input int fm);
        cfg_t c;
        pix_t e;
        int px, py, fc, w, k, lr, lg, lb;
        bit on, act;
        c  = get_cfg(d);
        px = n % line_px(d);
        py = (n / line_px(d)) % (frame_px(d) / line_px(d));
        fc = (n / frame_px(d) + 1) % 256;
        w  = (1 << CW) - 1;
        on = 0; lr = 0; lg = 0; lb = 0;
        case (fm)
            0: on = (px < c.border) || (px >= c.ha - c.border) ||
                    (py < c.border) || (py >= c.va - c.border);
            1: on = (px % (1 << c.g)) == 0;
            2: on = 1;
            3: on = (((px >> c.g) + (py >> c.g)) % 2) == 1;
            4: begin
                k  = (px * 8) / c.ha;
                lr = ((k / 4) % 2 == 1) ? w : 0;
                lg = ((k / 2) % 2 == 1) ? w : 0;
                lb = (k % 2 == 1) ? w : 0;
            end
            5: begin
                lr = (px >> c.g) % (1 << CW);
                lg = lr;
                lb = lr;
            end
            6: on = ((((px + py + fc) % 2048) >> c.g) % 2) == 1;
            default: on = 0;
        endcase
        if (on) begin
            lr = w; lg = w; lb = w;
        end
        act = (px < c.ha) && (py < c.va);
        if (!act) begin
            lr = 0; lg = 0; lb = 0;
        end
        e.is_rst = 1'b0;
        e.pix_en = 1'b1;
        e.fs     = (px == 0) && (py == 0);
        e.x      = 11'(px);
        e.y      = 11'(py);
        e.act    = act;
        e.hs     = ((px >= c.ha + c.hfp) && (px < c.ha + c.hfp + c.hs)) ? (c.hpol != 0) : (c.hpol == 0);
        e.vs     = ((py >= c.va + c.vfp) && (py < c.va + c.vfp + c.vs)) ? (c.vpol != 0) : (c.vpol == 0);
        e.r      = 3'(lr);
        e.g      = 3'(lg);
        e.b      = 3'(lb);
        e.fc     = 8'(fc);
        return e;
    endfunction

    // ---------------------------------------------------------------- scoreboard
    pix_t exp_q [2][$];
    int   m_cyc [2];
    int   m_n [2];
    int   m_fmode [2];

    // Stimulus side: each clk edge the model decides whether a pixel is
    // emitted and pushes its expected outputs.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_cyc[d]   = 0;
                m_n[d]     = 0;
                m_fmode[d] = 0;
                exp_q[d].push_back(reset_rec(d));
            end else begin
                if (m_cyc[d] % get_cfg(d).div == get_cfg(d).div - 1) begin
                    if (m_n[d] % frame_px(d) == 0) m_fmode[d] = int'(mode);
                    exp_q[d].push_back(model_pixel(d, m_n[d], m_fmode[d]));
                    m_n[d]++;
                end
                m_cyc[d]++;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at t=%0t", name, d, act, exp, $time);
        end
    endtask

    task automatic compare_all(input int d, input pix_t o, input pix_t e);
        chk("pix_en",      d, 32'(o.pix_en), 32'(e.pix_en));
        chk("frame_start", d, 32'(o.fs),     32'(e.fs));
        chk("x",           d, 32'(o.x),      32'(e.x));
        chk("y",           d, 32'(o.y),      32'(e.y));
        chk("active",      d, 32'(o.act),    32'(e.act));
        chk("hsync",       d, 32'(o.hs),     32'(e.hs));
        chk("vsync",       d, 32'(o.vs),     32'(e.vs));
        chk("r",           d, 32'(o.r),      32'(e.r));
        chk("g",           d, 32'(o.g),      32'(e.g));
        chk("b",           d, 32'(o.b),      32'(e.b));
        chk("frame_cnt",   d, 32'(o.fc),     32'(e.fc));
    endtask

    pix_t last_exp [2];
    bit   have_last [2];
    bit   fs_seen [2];
    int   last_fs_cyc [2];
    int   mon_cyc = 0;

    // Monitor: sampled on the falling edge, half a cycle after outputs move.
    always @(negedge clk) begin
        pix_t o, e;
        mon_cyc++;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) o = {1'b0, m_pix_en, m_fs, m_x, m_y, m_act, m_hs, m_vs, m_r, m_g, m_b, m_fc};
            else        o = {1'b0, s_pix_en, s_fs, s_x, s_y, s_act, s_hs, s_vs, s_r, s_g, s_b, s_fc};
            if (exp_q[d].size() > 0 && exp_q[d][0].is_rst) begin
                e = exp_q[d].pop_front();
                compare_all(d, o, e);
                last_exp[d]  = e;
                have_last[d] = 1'b1;
                fs_seen[d]   = 1'b0;
            end else if (o.pix_en) begin
                if (exp_q[d].size() == 0) begin
                    chk("pix_en_unexpected", d, 32'(o.pix_en), 32'd0);
                end else begin
                    e = exp_q[d].pop_front();
                    compare_all(d, o, e);
                    last_exp[d]  = e;
                    have_last[d] = 1'b1;
                end
                if (o.fs) begin
                    if (fs_seen[d])
                        chk("frame_period", d, 32'(mon_cyc - last_fs_cyc[d]),
                            32'(frame_px(d) * get_cfg(d).div));
                    fs_seen[d]     = 1'b1;
                    last_fs_cyc[d] = mon_cyc;
                end
            end else if (exp_q[d].size() > 0) begin
                chk("pix_en_missed", d, 32'(o.pix_en), 32'd1);
                void'(exp_q[d].pop_front());
            end else if (have_last[d]) begin
                e        = last_exp[d];
                e.pix_en = 1'b0;
                e.fs     = 1'b0;
                compare_all(d, o, e);
            end
        end
    end

    // ---------------------------------------------------------------- driver
    int perm [8];
    int j, t, w;

    initial begin
        rst_n = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) perm[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // One mode change at a random point inside each main frame; it must
        // only show from the following frame start.
        for (int f = 0; f < 8; f++) begin
            w = $urandom_range(200, M_FRAME_CLKS - 200);
            repeat (w) @(negedge clk);
            mode = 3'(perm[f]);
            repeat (M_FRAME_CLKS - w) @(negedge clk);
        end

        // Single-cycle reset in the middle of a frame.
        repeat ($urandom_range(1000, 4000)) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat ($urandom_range(500, 3000)) @(negedge clk);
        mode = 3'($urandom_range(0, 7));
        repeat (M_FRAME_CLKS + 500) @(negedge clk);

        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk("queue_drained", d, 32'(exp_q[d].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
